lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameters: none; address and data widths are fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 req_valid  in  1  pipeline memory request present.
REQ-005 req_ready  out  1  accepting; high only in IDLE; transfer occurs when req_valid & req_ready at a rising edge.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_func3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  32  extended load result; 0 for stores and errors.
REQ-012 resp_err  out  1  qualifies resp_valid: misaligned or illegal func3.
REQ-013 mem_writeEn  out  1  word-write strobe to the data memory.
REQ-014 mem_addr  out  32  word address to the data memory (bits [1:0] always 0).
REQ-015 mem_func3  out  3  latched request func3, forwarded.
REQ-016 mem_storeVal  out  32  full word to write.
REQ-017 mem_loadVal  in  32  word read; valid the cycle after the address is presented with mem_writeEn=0.
REQ-018 mem_data_ready  in  1  memory completion; high the cycle after any access.

Function
REQ-019 One request in flight; on acceptance, req_we, req_addr, req_func3 and req_wdata are latched; memory outputs are driven only from latched values.
REQ-020 States: IDLE, LD_RD, LD_CAP, ST_RD, ST_MRG, ST_WR, ST_WT, RESP, ERR.
REQ-021 Legality is checked at acceptance. Load func3 legal: 000, 001, 010, 100, 101. Store func3 legal: 000, 001, 010. Alignment: half requires addr[0]=0; word requires addr[1:0]=00. A failing request goes IDLE->ERR with no memory access.
REQ-022 Load path: IDLE->LD_RD (mem_addr driven, mem_writeEn=0)->LD_CAP (on mem_data_ready, capture extended mem_loadVal into resp_rdata)->RESP; resp_valid occurs 3 cycles after acceptance.
REQ-023 Load extraction is little-endian: byte lane = addr[1:0], half lane = addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word unchanged.
REQ-024 Word store path: IDLE->ST_WR (mem_writeEn=1 for exactly one cycle, mem_storeVal=wdata)->ST_WT (wait mem_data_ready)->RESP; resp_valid occurs 3 cycles after acceptance.
REQ-025 Sub-word store path (read-modify-write): IDLE->ST_RD (read)->ST_MRG (capture mem_loadVal; replace the addressed byte or half with wdata[7:0]/[15:0]; keep other bytes)->ST_WR->ST_WT->RESP; resp_valid occurs 5 cycles after acceptance.
REQ-026 LD_CAP and ST_WT hold their state while mem_data_ready=0; ST_MRG likewise waits for mem_data_ready.
REQ-027 RESP and ERR each last one cycle with resp_valid=1 and return to IDLE; resp_err=1 only in ERR. A new request can be accepted in the following cycle.
REQ-028 mem_writeEn=1 only in ST_WR. Outside active states, mem_addr=0 and mem_storeVal=0.
REQ-029 req_valid, and changes on the request inputs, while not in IDLE are ignored.

Reset
REQ-030 While reset=0: state=IDLE, all latches=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_writeEn=0, mem_addr=0, mem_storeVal=0, mem_func3=0, req_ready=1.
REQ-031 Reset asserted mid-operation aborts the request with no response. A write in ST_WR is suppressed unless the write edge has already occurred; no partial RMW write is ever issued.
REQ-032 Operation resumes on the first rising edge after reset deasserts.

Verification
REQ-033 Memory word 0x100 = 0x8899AABB; LB at 0x101 -> resp_rdata=0xFFFFFFAA at cycle 3; LBU at the same address -> 0x000000AA.
REQ-034 Word 0x200 = 0x11223344; SH wdata=0x0000BEEF at 0x202 -> single write of 0xBEEF3344 to 0x200; resp_valid at cycle 5; resp_err=0.
REQ-035 SW 0xDEADBEEF at 0x300, then LW at 0x300 -> exactly one mem_writeEn pulse; resp_rdata=0xDEADBEEF.
REQ-036 LW at 0x0000_0402, and a load with func3=011 -> resp_valid=1, resp_err=1 one cycle after acceptance; mem_writeEn never asserted.
REQ-037 reset=0 during ST_MRG of an SB -> memory unchanged, no resp_valid, req_ready=1 immediately; the next request completes normally.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response and data-memory signals of the load/store unit.
//   req_*  : pipeline request (valid/ready handshake, we, addr, func3, wdata)
//   resp_* : one-cycle completion pulse with load data and error flag
//   mem_*  : word-wide data memory port (address, write strobe, store/load data, ready)
// slave  : the LSU side.
// master : the environment side (pipeline plus data memory).
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_func3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_writeEn;
    logic [31:0] mem_addr;
    logic [2:0]  mem_func3;
    logic [31:0] mem_storeVal;
    logic [31:0] mem_loadVal;
    logic        mem_data_ready;

    modport slave (
        input  req_valid, req_we, req_addr, req_func3, req_wdata,
        input  mem_loadVal, mem_data_ready,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_writeEn, mem_addr, mem_func3, mem_storeVal
    );

    modport master (
        output req_valid, req_we, req_addr, req_func3, req_wdata,
        output mem_loadVal, mem_data_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_writeEn, mem_addr, mem_func3, mem_storeVal
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding RV32I load/store controller in front of a
// word-wide data memory. Sub-word stores are done as read-modify-write.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : lsu_ctrl_if.slave (request handshake, response pulse, memory port)
module lsu_ctrl (
    input  logic       clk,
    input  logic       reset,
    lsu_ctrl_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, LD_RD, LD_CAP, ST_RD, ST_MRG, ST_WR, ST_WT, RESP, ERR
    } state_t;

    state_t      state, state_nxt;
    logic        we_q;
    logic [31:0] addr_q, wdata_q, sdata_q, rdata_q;
    logic [2:0]  func3_q;

    // func3 / alignment legality; unsigned variants exist only for loads
    function automatic logic legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~a[0];
            3'b010:  ok = (a == 2'b00);
            3'b100:  ok = ~we;
            3'b101:  ok = ~we & ~a[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // little-endian lane extraction with sign/zero extension
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'b0, b};
            3'b101:  r = {16'b0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // replace the addressed byte/half of the old word, keep the rest
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (f3)
            3'b000:  r[{a, 3'b000} +: 8] = d[7:0];
            3'b001:  if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        bus.req_ready    = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.resp_err     = 1'b0;
        bus.resp_rdata   = 32'b0;
        bus.mem_writeEn  = 1'b0;
        bus.mem_addr     = 32'b0;
        bus.mem_storeVal = 32'b0;
        bus.mem_func3    = func3_q;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (!legal(bus.req_we, bus.req_func3, bus.req_addr[1:0])) state_nxt = ERR;
                    else if (!bus.req_we)                                     state_nxt = LD_RD;
                    else if (bus.req_func3 == 3'b010)                         state_nxt = ST_WR;
                    else                                                      state_nxt = ST_RD;
                end
            end
            LD_RD:  begin bus.mem_addr = {addr_q[31:2], 2'b00}; state_nxt = LD_CAP; end
            LD_CAP: begin
                bus.mem_addr = {addr_q[31:2], 2'b00};
                if (bus.mem_data_ready) state_nxt = RESP;
            end
            ST_RD:  begin bus.mem_addr = {addr_q[31:2], 2'b00}; state_nxt = ST_MRG; end
            ST_MRG: begin
                bus.mem_addr = {addr_q[31:2], 2'b00};
                if (bus.mem_data_ready) state_nxt = ST_WR;
            end
            ST_WR: begin
                bus.mem_addr     = {addr_q[31:2], 2'b00};
                bus.mem_storeVal = sdata_q;
                bus.mem_writeEn  = 1'b1;
                state_nxt        = ST_WT;
            end
            ST_WT: begin
                bus.mem_addr     = {addr_q[31:2], 2'b00};
                bus.mem_storeVal = sdata_q;
                if (bus.mem_data_ready) state_nxt = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = we_q ? 32'b0 : rdata_q;
                state_nxt      = IDLE;
            end
            ERR: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            addr_q  <= 32'b0;
            func3_q <= 3'b0;
            wdata_q <= 32'b0;
            sdata_q <= 32'b0;
            rdata_q <= 32'b0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                func3_q <= bus.req_func3;
                wdata_q <= bus.req_wdata;
                sdata_q <= bus.req_wdata;   // word stores write this directly
            end
            if (state == LD_CAP && bus.mem_data_ready)
                rdata_q <= load_ext(bus.mem_loadVal, addr_q[1:0], func3_q);
            if (state == ST_MRG && bus.mem_data_ready)
                sdata_q <= merge(bus.mem_loadVal, addr_q[1:0], func3_q, wdata_q);
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_ctrl_if bus();
    lsu_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

    // behavioural data memory: registered read, ready the cycle after each edge
    logic [31:0] mem [0:1023];
    logic        stall = 1'b0;
    int          wr_cnt = 0;
    int          cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_writeEn) begin
            mem[bus.mem_addr[11:2]] <= bus.mem_storeVal;
            wr_cnt <= wr_cnt + 1;
        end
        bus.mem_loadVal    <= mem[bus.mem_addr[11:2]];
        bus.mem_data_ready <= !stall;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] wdata, input int st, input logic [31:0] rdata,
                                input logic err, input int lat, input int nwr, input logic [31:0] word);
        vec_t v;
        v.we = we; v.addr = addr; v.f3 = f3; v.wdata = wdata; v.stall = st;
        v.rdata = rdata; v.err = err; v.lat = lat; v.nwr = nwr; v.word = word;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_func3 = v.f3;
        bus.req_wdata = v.wdata;
    endtask

    // one transaction; request lines stay asserted with junk while busy
    task automatic run(input vec_t v);
        exp_t e;
        int   acc, w0;
        bit   got;
        @(negedge clk);
        chk("idle_ready", bus.req_ready, 1);
        chk("idle_mem_addr", bus.mem_addr, 0);
        chk("idle_storeval", bus.mem_storeVal, 0);
        drive(v);
        stall = (v.stall > 0);
        acc = cyc;
        w0  = wr_cnt;
        e.rdata = v.rdata; e.err = v.err; e.lat = v.lat;
        sb.push_back(e);
        got = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            stall = (k < v.stall);
            if (k == 1) begin
                chk("mem_func3", bus.mem_func3, v.f3);
                chk("mem_addr", bus.mem_addr, v.err ? 32'h0 : {v.addr[31:2], 2'b00});
            end
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
            bus.req_we    = ~v.we;
            bus.req_func3 = 3'($urandom);
            if (bus.resp_valid) begin
                got = 1;
                bus.req_valid = 1'b0;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_rdata", bus.resp_rdata, e.rdata);
                    chk("resp_err", bus.resp_err, e.err);
                    chk("latency", 32'(cyc - acc), 32'(e.lat));
                end
                chk("write_count", 32'(wr_cnt - w0), 32'(v.nwr));
                chk("mem_word", mem[v.addr[11:2]], v.word);
            end
        end
        if (!got) begin
            bus.req_valid = 1'b0;
            chk("resp_timeout", 0, 1);
        end
        stall = 1'b0;
    endtask

    // reset at the k-th falling edge after acceptance: no response, no write
    task automatic abort(input vec_t v, input int at_k);
        int w0;
        @(negedge clk);
        drive(v);
        w0 = wr_cnt;
        for (int k = 1; k <= at_k; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
        reset = 1'b0;
        #1;
        chk("abort_ready", bus.req_ready, 1);
        chk("abort_resp_valid", bus.resp_valid, 0);
        chk("abort_we", bus.mem_writeEn, 0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_resp", bus.resp_valid, 0);
        end
        reset = 1'b1;
        chk("abort_writes", 32'(wr_cnt - w0), 0);
        chk("abort_mem_word", mem[v.addr[11:2]], v.word);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        mem[32'h100 >> 2] <= 32'h8899AABB;
        mem[32'h200 >> 2] <= 32'h11223344;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_func3 = 3'b0;
        bus.req_wdata = 32'h0;

        //            we    addr          f3    wdata         st rdata         err lat nwr word
        vecs.push_back(mk(0, 32'h101, 3'b000, 32'h0,        0, 32'hFFFFFFAA, 0, 3, 0, 32'h8899AABB));
        vecs.push_back(mk(0, 32'h101, 3'b100, 32'h0,        0, 32'h000000AA, 0, 3, 0, 32'h8899AABB));
        vecs.push_back(mk(0, 32'h102, 3'b001, 32'h0,        0, 32'hFFFF8899, 0, 3, 0, 32'h8899AABB));
        vecs.push_back(mk(0, 32'h100, 3'b101, 32'h0,        0, 32'h0000AABB, 0, 3, 0, 32'h8899AABB));
        vecs.push_back(mk(0, 32'h100, 3'b010, 32'h0,        0, 32'h8899AABB, 0, 3, 0, 32'h8899AABB));
        vecs.push_back(mk(1, 32'h202, 3'b001, 32'h0000BEEF, 0, 32'h0,        0, 5, 1, 32'hBEEF3344));
        vecs.push_back(mk(1, 32'h201, 3'b000, 32'h12345678, 0, 32'h0,        0, 5, 1, 32'hBEEF7844));
        vecs.push_back(mk(0, 32'h201, 3'b000, 32'h0,        0, 32'h00000078, 0, 3, 0, 32'hBEEF7844));
        vecs.push_back(mk(1, 32'h300, 3'b010, 32'hDEADBEEF, 0, 32'h0,        0, 3, 1, 32'hDEADBEEF));
        vecs.push_back(mk(0, 32'h300, 3'b010, 32'h0,        0, 32'hDEADBEEF, 0, 3, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 32'h402, 3'b010, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0));
        vecs.push_back(mk(0, 32'h100, 3'b011, 32'h0,        0, 32'h0,        1, 1, 0, 32'h8899AABB));
        vecs.push_back(mk(1, 32'h201, 3'b001, 32'hFFFF,     0, 32'h0,        1, 1, 0, 32'hBEEF7844));
        vecs.push_back(mk(1, 32'h200, 3'b100, 32'hFF,       0, 32'h0,        1, 1, 0, 32'hBEEF7844));
        vecs.push_back(mk(0, 32'h103, 3'b101, 32'h0,        0, 32'h0,        1, 1, 0, 32'h8899AABB));
        vecs.push_back(mk(0, 32'h100, 3'b010, 32'h0,        4, 32'h8899AABB, 0, 6, 0, 32'h8899AABB));
        vecs.push_back(mk(1, 32'h304, 3'b010, 32'hCAFEF00D, 4, 32'h0,        0, 6, 1, 32'hCAFEF00D));
        vecs.push_back(mk(1, 32'h103, 3'b000, 32'h000000FF, 2, 32'h0,        0, 6, 1, 32'hFF99AABB));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_we", bus.mem_writeEn, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_storeval", bus.mem_storeVal, 0);
        chk("rst_func3", bus.mem_func3, 0);
        reset = 1'b1;

        foreach (vecs[i]) run(vecs[i]);

        // reset in ST_MRG of a byte store, then in ST_WR of a word store
        abort(mk(1, 32'h100, 3'b000, 32'h11, 0, 32'h0, 0, 0, 0, 32'hFF99AABB), 2);
        abort(mk(1, 32'h300, 3'b010, 32'h0BADF00D, 0, 32'h0, 0, 0, 0, 32'hDEADBEEF), 1);
        run(mk(0, 32'h101, 3'b000, 32'h0, 0, 32'hFFFFFFAA, 0, 3, 0, 32'hFF99AABB));

        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
